wb_write_queue: RTL and testbench

//  Write-back queue directly upstream of the register-file storage flops
//  (negedge-write DFF cells). Merges ALU and LSU write-back requests.

---
 rtl/wb_write_queue.sv | 126 ++++++++++++
 tb/tb_wb_write_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// Write-back queue: merges LSU/ALU write-backs into an in-order FIFO and drains one registered one-hot write per cycle.
// Optional macro WBQ_FORWARD_EN adds a combinational forwarding search port (fwd_rd/fwd_hit/fwd_data).
module wb_write_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         lsu_valid,
    input  logic [ADDR_WIDTH-1:0]        lsu_rd,
    input  logic [DATA_WIDTH-1:0]        lsu_data,
    output logic                         lsu_ready,
    input  logic                         alu_valid,
    input  logic [ADDR_WIDTH-1:0]        alu_rd,
    input  logic [DATA_WIDTH-1:0]        alu_data,
    output logic                         alu_ready,
    output logic [(2**ADDR_WIDTH)-1:0]   rf_we,
    output logic [DATA_WIDTH-1:0]        rf_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
`ifdef WBQ_FORWARD_EN
    ,
    input  logic [ADDR_WIDTH-1:0]        fwd_rd,
    output logic                         fwd_hit,
    output logic [DATA_WIDTH-1:0]        fwd_data
`endif
);

    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] rd_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [NREG-1:0]       rf_we_q, rf_we_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

    logic                  lsu_acc, alu_acc, push, pop;
    logic [ADDR_WIDTH-1:0] in_rd;
    logic [DATA_WIDTH-1:0] in_data;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign lsu_ready = !full;
    assign alu_ready = !full && !lsu_valid;
    assign rf_we     = rf_we_q;
    assign rf_wdata  = rf_wdata_q;

    always_comb begin
        lsu_acc    = lsu_valid && lsu_ready;
        alu_acc    = alu_valid && alu_ready;
        in_rd      = lsu_valid ? lsu_rd : alu_rd;
        in_data    = lsu_valid ? lsu_data : alu_data;
        // x0 writes complete the handshake but are dropped here
        push       = (lsu_acc || alu_acc) && (in_rd != '0);
        pop        = !empty;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        rf_we_d    = pop ? (NREG'(1) << rd_mem[rd_ptr_q]) : '0;
        rf_wdata_d = pop ? data_mem[rd_ptr_q] : rf_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_q]   <= in_rd;
            data_mem[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

`ifdef WBQ_FORWARD_EN
    logic [ADDR_WIDTH-1:0] out_rd_q, out_rd_d;
    logic [PW-1:0]         idx;

    assign out_rd_d = pop ? rd_mem[rd_ptr_q] : out_rd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) out_rd_q <= '0;
        else        out_rd_q <= out_rd_d;
    end

    // Scan oldest to youngest so the youngest match overwrites earlier ones
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        if (fwd_rd != '0) begin
            if ((rf_we_q != '0) && (out_rd_q == fwd_rd)) begin
                fwd_hit  = 1'b1;
                fwd_data = rf_wdata_q;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + PW'(i);
                if ((CW'(i) < count_q) && (rd_mem[idx] == fwd_rd)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_mem[idx];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: directed scenarios then randomized traffic against a queue-based reference model.
module tb_wb_write_queue;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int NREG  = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk;
    logic            reset;
    logic            lsu_valid, alu_valid;
    logic [AW-1:0]   lsu_rd, alu_rd;
    logic [DW-1:0]   lsu_data, alu_data;
    logic            lsu_ready, alu_ready;
    logic [NREG-1:0] rf_we;
    logic [DW-1:0]   rf_wdata;
    logic [CW-1:0]   count;
    logic            full, empty;
    logic [AW-1:0]   fwd_rd;
    logic            fwd_hit;
    logic [DW-1:0]   fwd_data;

    wb_write_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .lsu_valid (lsu_valid),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .lsu_ready (lsu_ready),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .rf_we     (rf_we),
        .rf_wdata  (rf_wdata),
        .count     (count),
        .full      (full),
        .empty     (empty)
`ifdef WBQ_FORWARD_EN
        ,
        .fwd_rd    (fwd_rd),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
`endif
    );

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t            mq[$];
    logic [NREG-1:0] m_we;
    logic [DW-1:0]   m_wdata;
    logic [AW-1:0]   m_rd;
    int              checks;
    int              failures;
    logic            taken;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("rf_we", 64'(rf_we), 64'(m_we));
        chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        chk("count", 64'(count), 64'(mq.size()));
        chk("full", 64'(full), 64'(mq.size() == DEPTH));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
    endtask

`ifdef WBQ_FORWARD_EN
    task automatic chk_fwd();
        logic          hit;
        logic [DW-1:0] val;
        hit = 1'b0;
        val = '0;
        if (fwd_rd != '0) begin
            if (m_we != '0 && m_rd == fwd_rd) begin
                hit = 1'b1;
                val = m_wdata;
            end
            foreach (mq[k]) if (mq[k].rd == fwd_rd) begin
                hit = 1'b1;
                val = mq[k].data;
            end
        end
        chk("fwd_hit", 64'(fwd_hit), 64'(hit));
        chk("fwd_data", 64'(fwd_data), 64'(val));
    endtask
`endif

    // One cycle: drive at negedge, check readies, clock, advance model, check outputs
    task automatic step(input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                        input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                        output logic alu_taken);
        logic   lr, ar, lacc, aacc;
        ent_t   e;
        @(negedge clk);
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        #1;
        lr = (mq.size() != DEPTH);
        ar = lr && !lv;
        chk("lsu_ready", 64'(lsu_ready), 64'(lr));
        chk("alu_ready", 64'(alu_ready), 64'(ar));
`ifdef WBQ_FORWARD_EN
        chk_fwd();
`endif
        lacc = lv && lr;
        aacc = av && ar;
        alu_taken = aacc;
        @(posedge clk);
        #1;
        if (mq.size() > 0) begin
            e       = mq.pop_front();
            m_we    = NREG'(1) << e.rd;
            m_wdata = e.data;
            m_rd    = e.rd;
        end else begin
            m_we = '0;
        end
        if (lacc && lrd != '0) mq.push_back('{rd: lrd, data: ld});
        else if (aacc && ard != '0) mq.push_back('{rd: ard, data: ad});
        chk_outputs();
    endtask

    task automatic idle(input int n);
        logic t;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, t);
    endtask

    initial begin
        logic          av, alu_pend;
        logic [AW-1:0] ard;
        logic [DW-1:0] ad;

        checks = 0; failures = 0;
        mq = {}; m_we = '0; m_wdata = '0; m_rd = '0;
        lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        fwd_rd = '0;
        reset = 1'b0;
        #12;
        chk_outputs();
        @(negedge clk);
        reset = 1'b1;

        // single LSU write: one-cycle pulse after acceptance
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, taken);
        idle(1);
        chk("single_we", 64'(rf_we), 64'h20);
        chk("single_data", 64'(rf_wdata), 64'hDEADBEEF);
        idle(1);
        chk("single_we_off", 64'(rf_we), 64'h0);

        // conflict: LSU wins, ALU holds and follows
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, taken);
        chk("conflict_alu_taken", 64'(taken), 64'h0);
        step(1'b0, '0, '0, 1'b1, 5'd4, 32'h22, taken);
        chk("rd3_first", 64'(rf_we), 64'h8);
        idle(1);
        chk("rd4_second", 64'(rf_we), 64'h10);
        idle(1);

        // burst of 6 back-to-back, then 5 blocking cycles
        for (int i = 0; i < 6; i++) step(1'b1, AW'(i + 1), DW'(32'h100 + i), 1'b0, '0, '0, taken);
        for (int i = 0; i < 5; i++) step(1'b1, AW'(i + 10), DW'(32'h200 + i), 1'b1, 5'd20, 32'h300, taken);
        step(1'b0, '0, '0, 1'b1, 5'd20, 32'h300, taken);
        chk("alu_after_block", 64'(taken), 64'h1);
        idle(2);

        // x0 request: accepted but never stored
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'h55, taken);
        chk("x0_taken", 64'(taken), 64'h1);
        idle(2);
        chk("x0_no_we", 64'(rf_we), 64'h0);

`ifdef WBQ_FORWARD_EN
        step(1'b1, 5'd7, 32'h1, 1'b0, '0, '0, taken);
        step(1'b1, 5'd7, 32'h2, 1'b0, '0, '0, taken);
        @(negedge clk);
        fwd_rd = 5'd7; lsu_valid = 1'b0;
        #1;
        chk("fwd7_hit", 64'(fwd_hit), 64'h1);
        chk("fwd7_data", 64'(fwd_data), 64'h2);
        fwd_rd = 5'd0;
        #1;
        chk("fwd0_hit", 64'(fwd_hit), 64'h0);
        idle(3);
`endif

        // reset asserted mid-burst
        for (int i = 0; i < 3; i++) step(1'b1, AW'(i + 8), DW'(32'hA0 + i), 1'b1, 5'd9, 32'hB0, taken);
        @(negedge clk);
        #2;
        reset = 1'b0;
        lsu_valid = 1'b0; alu_valid = 1'b0;
        #1;
        mq = {}; m_we = '0; m_wdata = '0;
        chk_outputs();
        @(negedge clk);
        reset = 1'b1;
        idle(4);

        // randomized traffic; a losing ALU request is held until taken
        alu_pend = 1'b0; av = 1'b0; ard = '0; ad = '0;
        for (int c = 0; c < 400; c++) begin
            logic          lv;
            logic [AW-1:0] lrd;
            logic [DW-1:0] ld;
            lv  = ($urandom_range(0, 99) < 45);
            lrd = AW'($urandom_range(0, NREG - 1));
            ld  = $urandom;
            if (!alu_pend) begin
                av  = ($urandom_range(0, 99) < 50);
                ard = AW'($urandom_range(0, NREG - 1));
                ad  = $urandom;
            end
`ifdef WBQ_FORWARD_EN
            fwd_rd = AW'($urandom_range(0, NREG - 1));
`endif
            step(lv, lrd, ld, av, ard, ad, taken);
            alu_pend = av && !taken;
            chk("we_onehot", 64'($onehot0(rf_we) && !rf_we[0]), 64'h1);
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
